// File: rtl/object_bbox_tracker.sv
// Per-frame bounding boxes of a red marker (obj 0) and a blue marker (obj 1).
// Optional BBOX_SMOOTH_EN averages each new edge with the previous found box.
module object_bbox_tracker #(
  parameter int         H_ACTIVE   = 800,
  parameter int         V_ACTIVE   = 600,
  parameter logic [7:0] TH_HI      = 8'd160,
  parameter logic [7:0] TH_LO      = 8'd96,
  parameter int         MIN_PIXELS = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [10:0]      x,
  input  logic [10:0]      y,
  input  logic [2:0][7:0]  i_rgb,
  input  logic             i_frame_end,
  output logic [1:0][10:0] left,
  output logic [1:0][10:0] right,
  output logic [1:0][10:0] up,
  output logic [1:0][10:0] down,
  output logic [1:0]       o_found,
  output logic             predict_valid
);

  typedef enum logic [1:0] {ACCUM, COMMIT, PUBLISH} state_t;

  localparam logic [19:0] MINC = 20'(MIN_PIXELS);

  state_t r_state, w_next;

  logic [1:0][10:0] r_min_x, r_max_x, r_min_y, r_max_y;
  logic [1:0][19:0] r_cnt;
  logic [1:0][10:0] w_l, w_r, w_u, w_d;
  logic [1:0]       w_hit, w_ok;
  logic             w_in;

  assign w_in = ({1'b0, x} < 12'(H_ACTIVE)) &
                ({1'b0, y} < 12'(V_ACTIVE));

  assign w_hit[0] = i_valid & w_in & (i_rgb[0] >= TH_HI) &
                    (i_rgb[1] < TH_LO) & (i_rgb[2] < TH_LO);
  assign w_hit[1] = i_valid & w_in & (i_rgb[2] >= TH_HI) &
                    (i_rgb[0] < TH_LO) & (i_rgb[1] < TH_LO);

  assign w_ok[0] = r_cnt[0] >= MINC;
  assign w_ok[1] = r_cnt[1] >= MINC;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ACCUM;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    predict_valid = 1'b0;
    unique case (r_state)
      ACCUM:   if (i_frame_end) w_next = COMMIT;
      COMMIT:  w_next = PUBLISH;
      PUBLISH: begin
        w_next        = ACCUM;
        predict_valid = 1'b1;
      end
      default: w_next = ACCUM;
    endcase
  end

`ifdef BBOX_SMOOTH_EN
  function automatic logic [10:0] f_avg(input logic [10:0] a,
                                        input logic [10:0] b);
    logic [11:0] s;
    s = {1'b0, a} + {1'b0, b} + 12'd1;
    return s[11:1];
  endfunction

  // Average only when the previous committed box was a real detection.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_l[i] = o_found[i] ? f_avg(left[i],  r_min_x[i]) : r_min_x[i];
      w_r[i] = o_found[i] ? f_avg(right[i], r_max_x[i]) : r_max_x[i];
      w_u[i] = o_found[i] ? f_avg(up[i],    r_min_y[i]) : r_min_y[i];
      w_d[i] = o_found[i] ? f_avg(down[i],  r_max_y[i]) : r_max_y[i];
    end
  end
`else
  assign w_l = r_min_x;
  assign w_r = r_max_x;
  assign w_u = r_min_y;
  assign w_d = r_max_y;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_min_x[i] <= 11'h7ff;
        r_max_x[i] <= 11'h000;
        r_min_y[i] <= 11'h7ff;
        r_max_y[i] <= 11'h000;
        r_cnt[i]   <= 20'd0;
      end
    end else if (r_state == ACCUM) begin
      for (int i = 0; i < 2; i++) begin
        if (w_hit[i]) begin
          if (x < r_min_x[i]) r_min_x[i] <= x;
          if (x > r_max_x[i]) r_max_x[i] <= x;
          if (y < r_min_y[i]) r_min_y[i] <= y;
          if (y > r_max_y[i]) r_max_y[i] <= y;
          if (r_cnt[i] != 20'hfffff) r_cnt[i] <= r_cnt[i] + 20'd1;
        end
      end
    end else if (r_state == PUBLISH) begin
      for (int i = 0; i < 2; i++) begin
        r_min_x[i] <= 11'h7ff;
        r_max_x[i] <= 11'h000;
        r_min_y[i] <= 11'h7ff;
        r_max_y[i] <= 11'h000;
        r_cnt[i]   <= 20'd0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      left    <= '0;
      right   <= '0;
      up      <= '0;
      down    <= '0;
      o_found <= 2'b00;
    end else if (r_state == COMMIT) begin
      for (int i = 0; i < 2; i++) begin
        o_found[i] <= w_ok[i];
        if (w_ok[i]) begin
          left[i]  <= w_l[i];
          right[i] <= w_r[i];
          up[i]    <= w_u[i];
          down[i]  <= w_d[i];
        end
      end
    end
  end

endmodule
